// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Purpose  : Two-road Moore traffic light controller with min-green/yellow
//            timer and parade-mode hold of road B green.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int TW            = 8,
    parameter int MIN_GREEN     = 4,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    input  logic       M,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic [1:0] state_o
);

    localparam logic [1:0]    c_green      = 2'b00;
    localparam logic [1:0]    c_yellow     = 2'b01;
    localparam logic [1:0]    c_red        = 2'b10;
    localparam logic [TW-1:0] c_green_last = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] c_yel_last   = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] c_timer_max  = {TW{1'b1}};

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_la;
    logic [1:0]    r_lb;
    logic          w_green_done;
    logic          w_yellow_done;

    assign w_green_done  = (r_timer >= c_green_last);
    assign w_yellow_done = (r_timer == c_yel_last);

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = (w_green_done && (!TA || M)) ? S1 : S0;
            S1:      w_next = w_yellow_done ? S2 : S1;
            S2:      w_next = (w_green_done && !M && !TB) ? S3 : S2;
            S3:      w_next = w_yellow_done ? S0 : S3;
            default: w_next = S0;
        endcase
    end

    function automatic logic [1:0] f_light_a(input state_t s);
        case (s)
            S0:      f_light_a = c_green;
            S1:      f_light_a = c_yellow;
            default: f_light_a = c_red;
        endcase
    endfunction

    function automatic logic [1:0] f_light_b(input state_t s);
        case (s)
            S2:      f_light_b = c_green;
            S3:      f_light_b = c_yellow;
            default: f_light_b = c_red;
        endcase
    endfunction

    // Lights are registered from the next state so they always equal the
    // decode of the state register, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_timer <= '0;
            r_la    <= c_green;
            r_lb    <= c_red;
        end else begin
            r_state <= w_next;
            r_la    <= f_light_a(w_next);
            r_lb    <= f_light_b(w_next);
            if (w_next != r_state)
                r_timer <= '0;
            else if (r_timer != c_timer_max)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign LA      = r_la;
    assign LB      = r_lb;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl
// Purpose  : Vector table, directed corner sequences and randomized run
//            against a phase-level reference model of traffic_light_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int c_min_green = 4;
    localparam int c_yellow    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       TA;
    logic       TB;
    logic       M;
    logic [1:0] LA;
    logic [1:0] LB;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl #(
        .TW            (8),
        .MIN_GREEN     (c_min_green),
        .YELLOW_CYCLES (c_yellow)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .TA      (TA),
        .TB      (TB),
        .M       (M),
        .LA      (LA),
        .LB      (LB),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ta;
        logic       tb;
        logic       m;
        logic [1:0] la;
        logic [1:0] lb;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    // Reference model: which road owns the right of way, whether it is in
    // its yellow phase, and how many cycles the current phase has shown.
    int m_road;
    bit m_yel;
    int m_shown;

    task automatic model_edge(input logic r, input logic ta, input logic tb, input logic m);
        bit leave;
        if (r) begin
            m_road  = 0;
            m_yel   = 0;
            m_shown = 1;
        end else if (!m_yel) begin
            if (m_road == 0) leave = (m_shown >= c_min_green) && (!ta || m);
            else             leave = (m_shown >= c_min_green) && !m && !tb;
            if (leave) begin
                m_yel   = 1;
                m_shown = 1;
            end else begin
                m_shown++;
            end
        end else begin
            if (m_shown == c_yellow) begin
                m_yel   = 0;
                m_road  = 1 - m_road;
                m_shown = 1;
            end else begin
                m_shown++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [1:0] la_e, input logic [1:0] lb_e,
                       input logic [1:0] st_e);
        checks++;
        if (LA !== la_e || LB !== lb_e || state_o !== st_e) begin
            errors++;
            $display("FAIL %s @%0t: got LA=%b LB=%b state=%b, expected LA=%b LB=%b state=%b",
                     nm, $time, LA, LB, state_o, la_e, lb_e, st_e);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [1:0] la_e;
        logic [1:0] lb_e;
        logic [1:0] st_e;
        la_e = (m_road == 0) ? (m_yel ? 2'b01 : 2'b00) : 2'b10;
        lb_e = (m_road == 1) ? (m_yel ? 2'b01 : 2'b00) : 2'b10;
        st_e = 2'((m_road * 2) + int'(m_yel));
        chk(nm, la_e, lb_e, st_e);
    endtask

    task automatic step(input logic r, input logic ta, input logic tb, input logic m);
        reset = r;
        TA    = ta;
        TB    = tb;
        M     = m;
        @(posedge clk);
        model_edge(r, ta, tb, m);
        #1;
    endtask

    task automatic add(input logic r, input logic ta, input logic tb, input logic m,
                       input logic [1:0] la, input logic [1:0] lb, input logic [1:0] st,
                       input int n);
        vec_t v;
        v.rst = r; v.ta = ta; v.tb = tb; v.m = m; v.la = la; v.lb = lb; v.st = st;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; TA = 1'b0; TB = 1'b0; M = 1'b0;
        m_road = 0; m_yel = 0; m_shown = 1;

        // A release followed by B release.
        add(1, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2);
        add(0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 3);
        add(0, 0, 1, 0, 2'b01, 2'b10, 2'b01, 2);
        add(0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 10);
        add(0, 0, 0, 0, 2'b10, 2'b01, 2'b11, 2);
        add(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 4);
        add(0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ta, tbl[i].tb, tbl[i].m);
            chk($sformatf("table[%0d]", i), tbl[i].la, tbl[i].lb, tbl[i].st);
        end

        // Reset hold with traffic on A.
        step(1, 1, 0, 0); chk("rst_hold_r0", 2'b00, 2'b10, 2'b00);
        step(1, 1, 0, 0); chk("rst_hold_r1", 2'b00, 2'b10, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0); chk("rst_hold_ta", 2'b00, 2'b10, 2'b00);
        end

        // Parade: M rising in S0 finishes min green, yellow, then holds B.
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1); chk("parade_mingreen", 2'b00, 2'b10, 2'b00);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 1); chk("parade_yellow", 2'b01, 2'b10, 2'b01);
        end
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 0, 1); chk("parade_hold", 2'b10, 2'b00, 2'b10);
        end
        step(0, 1, 0, 0); chk("parade_release", 2'b10, 2'b01, 2'b11);

        // Reset in the middle of yellow.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("midyel_s1_t0", 2'b01, 2'b10, 2'b01);
        step(0, 0, 0, 0); chk("midyel_s1_t1", 2'b01, 2'b10, 2'b01);
        step(1, 0, 0, 0); chk("midyel_reset", 2'b00, 2'b10, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0); chk("midyel_green", 2'b00, 2'b10, 2'b00);
        end
        step(0, 0, 0, 0); chk("midyel_exit", 2'b01, 2'b10, 2'b01);

        // Timer saturation: long green, then prompt exit and exact yellow.
        step(1, 1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0); chk("sat_hold", 2'b00, 2'b10, 2'b00);
        end
        step(0, 0, 0, 0); chk("sat_exit", 2'b01, 2'b10, 2'b01);
        step(0, 0, 0, 0); chk("sat_yel2", 2'b01, 2'b10, 2'b01);
        step(0, 0, 0, 0); chk("sat_to_b", 2'b10, 2'b00, 2'b10);

        // Randomized run against the reference model; M is sticky.
        step(1, 0, 0, 0);
        chk_model("rand_start");
        begin
            logic m_r;
            m_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(15) == 0) m_r = ~m_r;
                step(($urandom_range(199) == 0), 1'($urandom), 1'($urandom), m_r);
                chk_model("rand");
                checks++;
                if ((LA != 2'b10 && LB != 2'b10) || LA == 2'b11 || LB == 2'b11) begin
                    errors++;
                    $display("FAIL invariant @%0t: got LA=%b LB=%b, expected one road red",
                             $time, LA, LB);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-road intersection controller (Academic road A, Bravado road B) that consumes parade-mode flag M from the parade-mode FSM. It drives the light codes for both roads. A Moore FSM with an internal cycle timer enforces a minimum green time and an exact yellow time. While M=1, road B is forced to green and held there.

Parameters:
TW, 8, timer width in bits
MIN_GREEN, 4, minimum cycles a green light is shown (1..2^TW-1)
YELLOW_CYCLES, 2, exact cycles a yellow light is shown (1..2^TW-1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
TA  input  1  traffic present on road A (synchronous to clk)
TB  input  1  traffic present on road B (synchronous to clk)
M  input  1  parade mode from parade-mode FSM, same clock domain, no synchronizer
LA  output  2  road A light: 00 green, 01 yellow, 10 red (11 never driven)
LB  output  2  road B light, same encoding
state_o  output  2  current state code, for debug/verification

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, named reset; it is sampled only on the rising edge of clk.
- States and codes:
  - S0=00: A green, B red.
  - S1=01: A yellow, B red.
  - S2=10: A red, B green.
  - S3=11: A red, B yellow.
- Outputs are pure Moore: a combinational decode of the state register only, with no dependence on the inputs.
- Reset (reset=1 at an edge):
  - state <= S0, timer <= 0.
  - Outputs during and after reset: LA=00, LB=10, state_o=00.
  - Reset overrides every other condition, including mid-yellow.
- Timer:
  - TW-bit counter, cleared to 0 on every state change.
  - Otherwise increments by 1 each cycle, saturating at 2^TW-1 (no wrap).
  - green_done = (timer >= MIN_GREEN-1).
  - yellow_done = (timer == YELLOW_CYCLES-1).
- Transitions, evaluated at each rising edge:
  - S0 -> S1 when green_done && (TA==0 || M==1); else stay.
  - S1 -> S2 when yellow_done; else stay. TA, TB and M are ignored.
  - S2 -> S3 when green_done && M==0 && TB==0; else stay. M==1 holds S2 indefinitely, regardless of TB.
  - S3 -> S0 when yellow_done; else stay. TA, TB and M are ignored.
  - Unreachable or illegal state: go to S0 with timer 0.
- Resulting timing:
  - Green is shown for at least MIN_GREEN cycles.
  - Yellow is shown for exactly YELLOW_CYCLES cycles.
  - Once the green minimum has elapsed, the exit from green takes effect at the first edge where the exit condition is true.
- M rising while in S0: A finishes its minimum green, then passes through yellow, then B is held green.
- M rising while in S1 or S3: the yellow phase completes normally; no abort.
- M falling while in S2 with TB=0 and green_done: S3 at the next edge.
- Both roads are never green or yellow simultaneously. LA!=10 implies LB==10, and vice versa (invariant).

Test Plan:
1. Reset hold: reset=1 for 2 edges, then TA=1, M=0 for 20 cycles -> LA=00, LB=10, state_o=00 throughout.
2. A release: after reset, TA=0, TB=1, M=0 -> LA=00 for 4 cycles, LA=01 for exactly 2 cycles, then LA=10/LB=00 and held while TB=1.
3. B release: in S2, drop TB=0 after 10 cycles -> S3 at the next edge; LB=01 for 2 cycles; then S0 with LA=00, LB=10.
4. Parade: in S0 with TA=1, assert M=1 -> S1 once the minimum green has elapsed, S2 after 2 cycles, S2 held 30 cycles with TB=0. Drop M -> state_o=11 at the next edge.
5. Reset mid-yellow: in S1 with timer=1, pulse reset for 1 edge -> state_o=00, LA=00, LB=10 at that edge. Then, with TA=0, LA=00 for a full 4 cycles.
6. Timer saturation: TA=1 in S0 for 300 cycles (timer saturates at 255), then TA=0 -> S1 at the very next edge, and yellow lasts exactly 2 cycles.
